// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register, sitting directly
//   upstream of decode. Owns the PC, issues instruction-memory requests,
//   applies decode-driven redirects (jump/call, branch, return, refetch) and
//   parks one instruction fetched during a stall in a skid buffer so it does
//   not need to be fetched again.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous, active-high reset
//   stall          load-use stall from decode: IF/ID holds
//   kill           redirect from decode: overrides stall, inserts a bubble
//   PcSrc          redirect select: 0 current pc, 1 jump_target,
//                  2 branch_target, 3 return_addr
//   jump_target    redirect target for JMP/CALL
//   branch_target  redirect target for a taken branch
//   return_addr    redirect target for RET
//   imem_addr      fetch address (the pc register)
//   imem_req       fetch request, low while the skid buffer is occupied
//   imem_rdata     instruction word, valid in the cycle imem_ready=1
//   imem_ready     fetch completes this cycle
//   id_instr       IF/ID instruction (NOP_INSTR when id_valid=0)
//   id_pc          IF/ID instruction address
//   id_pc_plus1    IF/ID instruction address + 1 (mod 2^WIDTH)
//   id_valid       IF/ID holds a real instruction
module fetch_stage #(
    parameter int unsigned     WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             kill,
    input  logic [1:0]       PcSrc,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] return_addr,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus1,
    output logic             id_valid
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Which update the stage performs at the next edge, in priority order.
    typedef enum logic [2:0] {
        ACT_REDIRECT,   // kill: load new pc, bubble IF/ID, drop skid entry
        ACT_STALL,      // stall: IF/ID holds, a completed fetch is parked
        ACT_DRAIN,      // skid entry moves into IF/ID
        ACT_ADVANCE,    // fetched word moves into IF/ID
        ACT_BUBBLE      // nothing to deliver
    } action_e;

    // Program counter and skid buffer
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [WIDTH-1:0] hold_pc_q, hold_pc_d;

    // IF/ID register
    logic [WIDTH-1:0] id_instr_q, id_instr_d;
    logic [WIDTH-1:0] id_pc_q, id_pc_d;
    logic [WIDTH-1:0] id_pc_plus1_q, id_pc_plus1_d;
    logic             id_valid_q, id_valid_d;

    logic             fetch_done;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] redirect_pc;
    action_e          action;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    assign imem_addr  = pc_q;
    assign imem_req   = !hold_valid_q;
    assign fetch_done = imem_req & imem_ready;
    assign pc_plus1   = pc_q + ONE;

    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus1 = id_pc_plus1_q;
    assign id_valid    = id_valid_q;

    // Targets are only looked at when kill is asserted, so X on an unused
    // target cannot reach state.
    always_comb begin
        redirect_pc = pc_q;
        unique case (PcSrc)
            2'd0: redirect_pc = pc_q;
            2'd1: redirect_pc = jump_target;
            2'd2: redirect_pc = branch_target;
            2'd3: redirect_pc = return_addr;
            default: redirect_pc = pc_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Action select
    // ------------------------------------------------------------------
    always_comb begin
        action = ACT_BUBBLE;
        if (kill)
            action = ACT_REDIRECT;
        else if (stall)
            action = ACT_STALL;
        else if (hold_valid_q)
            action = ACT_DRAIN;
        else if (fetch_done)
            action = ACT_ADVANCE;
        else
            action = ACT_BUBBLE;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        hold_valid_d  = hold_valid_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus1_d = id_pc_plus1_q;
        id_valid_d    = id_valid_q;

        unique case (action)
            ACT_REDIRECT: begin
                // Any word returned this cycle is wrong-path and dropped.
                pc_d         = redirect_pc;
                hold_valid_d = 1'b0;
                id_valid_d   = 1'b0;
                id_instr_d   = NOP_INSTR;
            end
            ACT_STALL: begin
                // IF/ID holds. A fetch completing now is parked; since
                // imem_req drops while parked, at most one entry is ever held.
                if (fetch_done) begin
                    hold_instr_d = imem_rdata;
                    hold_pc_d    = pc_q;
                    hold_valid_d = 1'b1;
                    pc_d         = pc_plus1;
                end
            end
            ACT_DRAIN: begin
                // pc already points past the parked word, so it holds.
                id_instr_d    = hold_instr_q;
                id_pc_d       = hold_pc_q;
                id_pc_plus1_d = hold_pc_q + ONE;
                id_valid_d    = 1'b1;
                hold_valid_d  = 1'b0;
            end
            ACT_ADVANCE: begin
                id_instr_d    = imem_rdata;
                id_pc_d       = pc_q;
                id_pc_plus1_d = pc_plus1;
                id_valid_d    = 1'b1;
                pc_d          = pc_plus1;
            end
            ACT_BUBBLE: begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
            default: begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            hold_valid_q  <= 1'b0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus1_q <= '0;
            id_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            hold_valid_q  <= hold_valid_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus1_q <= id_pc_plus1_d;
            id_valid_q    <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'hF00F;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        kill;
    logic [1:0]  PcSrc;
    logic [15:0] jump_target;
    logic [15:0] branch_target;
    logic [15:0] return_addr;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus1;
    logic        id_valid;

    int vectors = 0;
    int errors  = 0;

    fetch_stage #(
        .WIDTH    (16),
        .RESET_PC (16'h0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .kill         (kill),
        .PcSrc        (PcSrc),
        .jump_target  (jump_target),
        .branch_target(branch_target),
        .return_addr  (return_addr),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc_plus1  (id_pc_plus1),
        .id_valid     (id_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at addr is A000|addr.
    assign imem_rdata = 16'hA000 | imem_addr;

    // Advance one edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; kill = 1'b0; PcSrc = 2'd0;
        jump_target = '0; branch_target = '0; return_addr = '0;
        imem_ready = 1'b1;
        step();
        vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_valid); end
        vectors++; if (id_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", id_instr, NOP); end
        vectors++; if (id_pc !== 16'h0000 || id_pc_plus1 !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h/%h exp 0000/0000", id_pc, id_pc_plus1); end
        vectors++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem got %h/%b exp 0000/1", imem_addr, imem_req); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        // Targets are X while kill=0 and must be ignored.
        jump_target = 'x; branch_target = 'x; return_addr = 'x;
        step();
        vectors++; if (id_pc !== 16'h0000 || id_instr !== 16'hA000 || id_valid !== 1'b1) begin errors++; $display("FAIL stream_e1 got pc=%h instr=%h v=%b exp 0000 A000 1", id_pc, id_instr, id_valid); end
        vectors++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL stream_addr1 got %h exp 0001", imem_addr); end
        step();
        vectors++; if (id_pc !== 16'h0001 || id_pc_plus1 !== 16'h0002 || id_instr !== 16'hA001) begin errors++; $display("FAIL stream_e2 got %h/%h/%h exp 0001/0002/A001", id_pc, id_pc_plus1, id_instr); end
        step();
        vectors++; if (id_pc !== 16'h0002 || imem_addr !== 16'h0003) begin errors++; $display("FAIL stream_e3 got pc=%h addr=%h exp 0002 0003", id_pc, imem_addr); end
        jump_target = '0; branch_target = '0; return_addr = '0;
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_addr !== 16'h0003) begin errors++; $display("FAIL ready_low_bubble%0d got v=%b instr=%h addr=%h exp 0 %h 0003", i, id_valid, id_instr, imem_addr, NOP); end
        end
        imem_ready = 1'b1;
        step();
        vectors++; if (id_pc !== 16'h0003 || id_valid !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("FAIL ready_resume got pc=%h v=%b addr=%h exp 0003 1 0004", id_pc, id_valid, imem_addr); end
        step();
        vectors++; if (id_pc !== 16'h0004) begin errors++; $display("FAIL ready_next got %h exp 0004", id_pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        step();   // stall cycle 1: pc 5 parked, pc -> 6
        vectors++; if (id_pc !== 16'h0004 || id_valid !== 1'b1) begin errors++; $display("FAIL stall1_hold got pc=%h v=%b exp 0004 1", id_pc, id_valid); end
        for (int i = 2; i <= 3; i++) begin
            vectors++; if (imem_req !== 1'b0 || imem_addr !== 16'h0006) begin errors++; $display("FAIL stall%0d_req got req=%b addr=%h exp 0 0006", i, imem_req, imem_addr); end
            step();
            vectors++; if (id_pc !== 16'h0004) begin errors++; $display("FAIL stall%0d_hold got %h exp 0004", i, id_pc); end
        end
        stall = 1'b0;
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_req got %b exp 0", imem_req); end
        step();
        vectors++; if (id_pc !== 16'h0005 || id_pc_plus1 !== 16'h0006 || id_instr !== 16'hA005 || id_valid !== 1'b1) begin errors++; $display("FAIL drain got %h/%h/%h/%b exp 0005/0006/A005/1", id_pc, id_pc_plus1, id_instr, id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin errors++; $display("FAIL drain_resume got req=%b addr=%h exp 1 0006", imem_req, imem_addr); end
        step();
        vectors++; if (id_pc !== 16'h0006 || id_valid !== 1'b1) begin errors++; $display("FAIL after_drain got pc=%h v=%b exp 0006 1", id_pc, id_valid); end
    endtask

    task automatic test_kill_branch();
        stall = 1'b1;
        step();   // pc 7 parked, pc -> 8
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 16'h0008) begin errors++; $display("FAIL kb_park got req=%b addr=%h exp 0 0008", imem_req, imem_addr); end
        stall = 1'b0; kill = 1'b1; PcSrc = 2'd2; branch_target = 16'h0020;
        step();
        kill = 1'b0;
        vectors++; if (id_valid !== 1'b0 || id_instr !== NOP) begin errors++; $display("FAIL kb_bubble got v=%b instr=%h exp 0 %h", id_valid, id_instr, NOP); end
        vectors++; if (imem_addr !== 16'h0020 || imem_req !== 1'b1) begin errors++; $display("FAIL kb_target got addr=%h req=%b exp 0020 1", imem_addr, imem_req); end
        step();
        vectors++; if (id_pc !== 16'h0020 || id_instr !== 16'hA020 || id_valid !== 1'b1) begin errors++; $display("FAIL kb_fetch got %h/%h/%b exp 0020/A020/1", id_pc, id_instr, id_valid); end
    endtask

    task automatic test_kill_over_stall();
        stall = 1'b1; kill = 1'b1; PcSrc = 2'd3; return_addr = 16'h0007;
        step();
        stall = 1'b0; kill = 1'b0;
        vectors++; if (id_valid !== 1'b0 || imem_addr !== 16'h0007 || imem_req !== 1'b1) begin errors++; $display("FAIL ks_bubble got v=%b addr=%h req=%b exp 0 0007 1", id_valid, imem_addr, imem_req); end
        step();
        vectors++; if (id_pc !== 16'h0007 || id_valid !== 1'b1) begin errors++; $display("FAIL ks_fetch got pc=%h v=%b exp 0007 1", id_pc, id_valid); end
    endtask

    task automatic test_jump_wrap();
        kill = 1'b1; PcSrc = 2'd1; jump_target = 16'hFFFF;
        step();
        kill = 1'b0;
        vectors++; if (id_valid !== 1'b0 || imem_addr !== 16'hFFFF) begin errors++; $display("FAIL jw_bubble got v=%b addr=%h exp 0 FFFF", id_valid, imem_addr); end
        step();
        vectors++; if (id_pc !== 16'hFFFF || id_pc_plus1 !== 16'h0000 || id_instr !== 16'hFFFF) begin errors++; $display("FAIL jw_wrap got %h/%h/%h exp FFFF/0000/FFFF", id_pc, id_pc_plus1, id_instr); end
        vectors++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL jw_next_addr got %h exp 0000", imem_addr); end
        step();
        vectors++; if (id_pc !== 16'h0000 || id_pc_plus1 !== 16'h0001) begin errors++; $display("FAIL jw_after got %h/%h exp 0000/0001", id_pc, id_pc_plus1); end
    endtask

    task automatic test_refetch();
        // PcSrc=0 reloads the current pc (1) after one bubble.
        kill = 1'b1; PcSrc = 2'd0; jump_target = 16'h1234;
        step();
        kill = 1'b0;
        vectors++; if (id_valid !== 1'b0 || imem_addr !== 16'h0001) begin errors++; $display("FAIL rf_bubble got v=%b addr=%h exp 0 0001", id_valid, imem_addr); end
        step();
        vectors++; if (id_pc !== 16'h0001 || id_valid !== 1'b1 || imem_addr !== 16'h0002) begin errors++; $display("FAIL rf_fetch got pc=%h v=%b addr=%h exp 0001 1 0002", id_pc, id_valid, imem_addr); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        step();   // pc 2 parked, pc -> 3
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 16'h0003) begin errors++; $display("FAIL ar_park got req=%b addr=%h exp 0 0003", imem_req, imem_addr); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 16'h0000 || id_pc_plus1 !== 16'h0000) begin errors++; $display("FAIL ar_ifid got v=%b instr=%h pc=%h p1=%h exp 0 %h 0000 0000", id_valid, id_instr, id_pc, id_pc_plus1, NOP); end
        vectors++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin errors++; $display("FAIL ar_imem got addr=%h req=%b exp 0000 1", imem_addr, imem_req); end
        step();
        stall = 1'b0; reset = 1'b0;
        step();
        vectors++; if (id_pc !== 16'h0000 || id_instr !== 16'hA000 || id_valid !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL ar_restart got %h/%h/%b addr=%h exp 0000/A000/1 0001", id_pc, id_instr, id_valid, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_low();
        test_stall();
        test_kill_branch();
        test_kill_over_stall();
        test_jump_wrap();
        test_refetch();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
